// File: rtl/alu_seq_unit.sv
// Sequential ALU with registered Out/Flags. Single-cycle arithmetic and logic ops,
// bit-serial shifts and a shift-add multiplier, on staged opcode/src/dest registers.
module alu_seq_unit #(
   parameter int WIDTH = 16,
   parameter int IN_W  = 10,
   parameter bit SEXT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IN_W-1:0]  data_input,
   input  logic             ld_op_code,
   input  logic             ld_src,
   input  logic             ld_dest,
   input  logic             ld_acc,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [4:0]       Flags,
   output logic [WIDTH-1:0] Out,
   output logic [1:0]       dbg_state
);
   localparam int SH_W  = $clog2(WIDTH);
   localparam int CNT_W = SH_W + 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_CMP = 4'd6;
   localparam logic [3:0] OP_LSH = 4'd7;
   localparam logic [3:0] OP_RSH = 4'd8;
   localparam logic [3:0] OP_ASH = 4'd9;
   localparam logic [3:0] OP_MUL = 4'd10;

   // Flag bit positions within {N,Z,F,L,C}
   localparam int FN = 4;
   localparam int FZ = 3;
   localparam int FF = 2;
   localparam int FL = 1;
   localparam int FC = 0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [3:0]       op_q;
   logic [3:0]       iter_op_q;
   logic [WIDTH-1:0] src_q;
   logic [WIDTH-1:0] dest_q;
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [4:0]       flags_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] ext_in;
   logic [WIDTH:0]   add_w;
   logic [WIDTH:0]   sub_w;
   logic [SH_W-1:0]  shamt;
   logic [WIDTH-1:0] sc_out_d;
   logic [4:0]       sc_flags_d;
   logic             sc_nz;
   logic             go_iter;
   logic [WIDTH-1:0] step_d;

   always_comb begin
      ext_in = '0;
      ext_in[IN_W-1:0] = data_input;
      for (int i = IN_W; i < WIDTH; i++) begin
         ext_in[i] = SEXT & data_input[IN_W-1];
      end
   end

   assign add_w = {1'b0, dest_q} + {1'b0, src_q};
   assign sub_w = {1'b0, dest_q} - {1'b0, src_q};
   assign shamt = src_q[SH_W-1:0];

   // Result of an op that finishes on the start edge; go_iter selects the serial path instead.
   always_comb begin
      sc_out_d   = out_q;
      sc_flags_d = flags_q;
      sc_nz      = 1'b0;
      go_iter    = 1'b0;
      case (op_q)
         OP_ADD: begin
            sc_out_d       = add_w[WIDTH-1:0];
            sc_flags_d[FC] = add_w[WIDTH];
            sc_flags_d[FF] = (dest_q[WIDTH-1] == src_q[WIDTH-1]) &&
                             (add_w[WIDTH-1] != dest_q[WIDTH-1]);
            sc_nz          = 1'b1;
         end
         OP_SUB: begin
            sc_out_d       = sub_w[WIDTH-1:0];
            sc_flags_d[FC] = sub_w[WIDTH];
            sc_flags_d[FF] = (dest_q[WIDTH-1] != src_q[WIDTH-1]) &&
                             (sub_w[WIDTH-1] != dest_q[WIDTH-1]);
            sc_nz          = 1'b1;
         end
         OP_AND: begin
            sc_out_d = dest_q & src_q;
            sc_nz    = 1'b1;
         end
         OP_OR: begin
            sc_out_d = dest_q | src_q;
            sc_nz    = 1'b1;
         end
         OP_XOR: begin
            sc_out_d = dest_q ^ src_q;
            sc_nz    = 1'b1;
         end
         OP_NOT: begin
            sc_out_d = ~dest_q;
            sc_nz    = 1'b1;
         end
         OP_CMP: begin
            sc_flags_d[FL] = dest_q < src_q;
            sc_flags_d[FN] = $signed(dest_q) < $signed(src_q);
            sc_flags_d[FZ] = dest_q == src_q;
         end
         OP_LSH, OP_RSH, OP_ASH: begin
            if (shamt == '0) begin
               sc_out_d = dest_q;
               sc_nz    = 1'b1;
            end else begin
               go_iter = 1'b1;
            end
         end
         OP_MUL: go_iter = 1'b1;
         default: sc_nz = 1'b0;
      endcase
      if (sc_nz) begin
         sc_flags_d[FN] = sc_out_d[WIDTH-1];
         sc_flags_d[FZ] = (sc_out_d == '0);
      end
   end

   always_comb begin
      step_d = work_q;
      case (iter_op_q)
         OP_LSH:  step_d = {work_q[WIDTH-2:0], 1'b0};
         OP_RSH:  step_d = {1'b0, work_q[WIDTH-1:1]};
         OP_ASH:  step_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
         OP_MUL:  step_d = mplier_q[0] ? (work_q + mcand_q) : work_q;
         default: step_d = work_q;
      endcase
   end

   // start is accepted only in IDLE; busy marks ITER; done pulses for the one cycle after Out/Flags update.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         iter_op_q <= '0;
         src_q     <= '0;
         dest_q    <= '0;
         out_q     <= '0;
         work_q    <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         flags_q   <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ld_op_code) op_q <= data_input[3:0];
               if (ld_src) src_q <= ext_in;
               if (ld_acc) dest_q <= out_q;
               else if (ld_dest) dest_q <= ext_in;
               if (start) begin
                  if (go_iter) begin
                     state_q   <= S_ITER;
                     busy_q    <= 1'b1;
                     iter_op_q <= op_q;
                     cnt_q     <= (op_q == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(shamt);
                     work_q    <= (op_q == OP_MUL) ? '0 : dest_q;
                     mcand_q   <= dest_q;
                     mplier_q  <= src_q;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     out_q   <= sc_out_d;
                     flags_q <= sc_flags_d;
                  end
               end
            end
            S_ITER: begin
               work_q   <= step_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q     <= S_DONE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  out_q       <= step_d;
                  flags_q[FN] <= step_d[WIDTH-1];
                  flags_q[FZ] <= (step_d == '0);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign Flags     = flags_q;
   assign Out       = out_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed and randomized checks of alu_seq_unit against an arithmetic reference model
// that derives results, flags and latency directly from the operation definitions.
module tb_alu_seq_unit;
   localparam int W      = 16;
   localparam int IN_W   = 10;
   localparam bit SEXT   = 1'b0;
   localparam int SH_MOD = 1 << $clog2(W);
   localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
   localparam longint MINS = -(longint'(1) << (W - 1));

   logic            clk = 1'b0;
   logic            reset;
   logic [IN_W-1:0] data_input;
   logic            ld_op_code, ld_src, ld_dest, ld_acc, start;
   logic            busy, done;
   logic [4:0]      Flags;
   logic [W-1:0]    Out;
   logic [1:0]      dbg_state;

   alu_seq_unit #(.WIDTH(W), .IN_W(IN_W), .SEXT(SEXT)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .data_input (data_input),
      .ld_op_code (ld_op_code),
      .ld_src     (ld_src),
      .ld_dest    (ld_dest),
      .ld_acc     (ld_acc),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .Flags      (Flags),
      .Out        (Out),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [W+4:0] exp_q[$];
   int           lat_q[$];

   // reference model state; flags held as {N,Z,F,L,C}
   logic [3:0]   m_op;
   logic [W-1:0] m_src, m_dest, m_out;
   logic [4:0]   m_flags;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      data_input = '0;
      ld_op_code = 1'b0;
      ld_src     = 1'b0;
      ld_dest    = 1'b0;
      ld_acc     = 1'b0;
      start      = 1'b0;
   endtask

   task automatic drive_garbage();
      data_input = IN_W'($urandom);
      ld_op_code = 1'($urandom_range(0, 1));
      ld_src     = 1'($urandom_range(0, 1));
      ld_dest    = 1'($urandom_range(0, 1));
      ld_acc     = 1'($urandom_range(0, 1));
      start      = 1'($urandom_range(0, 1));
   endtask

   function automatic logic [W-1:0] extend(input logic [IN_W-1:0] v);
      longint s;
      s = longint'(v);
      if (SEXT && v[IN_W-1]) s = s - (longint'(1) << IN_W);
      return s[W-1:0];
   endfunction

   task automatic model_reset();
      m_op = '0; m_src = '0; m_dest = '0; m_out = '0; m_flags = '0;
   endtask

   task automatic model_apply_loads(input bit lop, lsrc, ldst, lacc, input logic [IN_W-1:0] v);
      if (lop) m_op = v[3:0];
      if (lsrc) m_src = extend(v);
      if (lacc) m_dest = m_out;
      else if (ldst) m_dest = extend(v);
   endtask

   task automatic model_eval(output logic [W-1:0] o, output logic [4:0] f, output int lat);
      longint sd, ss, r;
      int k;
      logic signed [W-1:0] t;
      logic [63:0] prod;
      o = m_out; f = m_flags; lat = 1;
      sd = longint'($signed(m_dest));
      ss = longint'($signed(m_src));
      k  = int'(m_src) % SH_MOD;
      case (m_op)
         4'd0: begin
            o = m_dest + m_src;
            f[0] = (longint'(m_dest) + longint'(m_src)) >= (longint'(1) << W);
            r = sd + ss;
            f[2] = (r > MAXS) || (r < MINS);
         end
         4'd1: begin
            o = m_dest - m_src;
            f[0] = m_dest < m_src;
            r = sd - ss;
            f[2] = (r > MAXS) || (r < MINS);
         end
         4'd2: o = m_dest & m_src;
         4'd3: o = m_dest | m_src;
         4'd4: o = m_dest ^ m_src;
         4'd5: o = ~m_dest;
         4'd6: begin
            f[1] = m_dest < m_src;
            f[4] = sd < ss;
            f[3] = m_dest == m_src;
         end
         4'd7: begin o = m_dest << k; lat = k + 1; end
         4'd8: begin o = m_dest >> k; lat = k + 1; end
         4'd9: begin t = m_dest; t = t >>> k; o = t; lat = k + 1; end
         4'd10: begin
            prod = 64'(longint'(m_dest) * longint'(m_src));
            o = prod[W-1:0];
            lat = W + 1;
         end
         default: lat = 1;
      endcase
      if (m_op <= 4'd10 && m_op != 4'd6) begin
         f[4] = o[W-1];
         f[3] = (o == '0);
      end
   endtask

   // driver tasks
   task automatic load(input bit lop, lsrc, ldst, lacc, input logic [IN_W-1:0] v);
      model_apply_loads(lop, lsrc, ldst, lacc, v);
      data_input = v; ld_op_code = lop; ld_src = lsrc; ld_dest = ldst; ld_acc = lacc;
      tick();
      clear_inputs();
   endtask

   task automatic setup(input logic [3:0] op, input logic [IN_W-1:0] dv, input logic [IN_W-1:0] sv);
      load(1'b1, 1'b0, 1'b0, 1'b0, IN_W'(op));
      load(1'b0, 1'b0, 1'b1, 1'b0, dv);
      load(1'b0, 1'b1, 1'b0, 1'b0, sv);
   endtask

   task automatic start_op(input bit lop, lsrc, ldst, lacc, input logic [IN_W-1:0] v);
      logic [W-1:0] o;
      logic [4:0]   f;
      int           lat;
      model_eval(o, f, lat);
      exp_q.push_back({f, o});
      lat_q.push_back(lat);
      model_apply_loads(lop, lsrc, ldst, lacc, v);
      m_out = o; m_flags = f;
      data_input = v; ld_op_code = lop; ld_src = lsrc; ld_dest = ldst; ld_acc = lacc;
      start = 1'b1;
      tick();
      clear_inputs();
   endtask

   // scoreboard: pops the expected result when done is seen
   task automatic wait_done();
      int cyc, busy_cyc, lat;
      logic [W+4:0] e;
      cyc = 1; busy_cyc = 0;
      while (done !== 1'b1 && cyc <= 64) begin
         if (busy === 1'b1) busy_cyc++;
         drive_garbage();
         tick();
         cyc++;
      end
      e   = exp_q.pop_front();
      lat = lat_q.pop_front();
      check_eq("done_seen", 32'(done), 32'd1);
      if (done === 1'b1) begin
         check_eq("latency", cyc, lat);
         check_eq("busy_cycles", busy_cyc, lat - 1);
         check_eq("busy_in_done", 32'(busy), 32'd0);
         check_eq("out", 32'(Out), 32'(e[W-1:0]));
         check_eq("flags", 32'(Flags), 32'(e[W+4:W]));
         drive_garbage();
         tick();
         clear_inputs();
         check_eq("done_one_cycle", 32'(done), 32'd0);
      end
      clear_inputs();
   endtask

   initial begin
      bit saw_done;
      logic [3:0] rop;
      clear_inputs();
      reset = 1'b1;
      model_reset();
      repeat (3) tick();
      check_eq("rst_out", 32'(Out), 32'd0);
      check_eq("rst_flags", 32'(Flags), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'd0);
      reset = 1'b0;
      tick();

      // OR
      setup(4'd3, 10'h004, 10'h003);
      start_op(1'b0, 1'b0, 1'b0, 1'b0, '0);
      wait_done();
      check_eq("or_out", 32'(Out), 32'h0007);

      // LSH with start/ld_src noise while iterating
      setup(4'd7, 10'h005, 10'h003);
      start_op(1'b0, 1'b0, 1'b0, 1'b0, '0);
      wait_done();
      check_eq("lsh_out", 32'(Out), 32'h0028);

      // MUL
      setup(4'd10, 10'h00C, 10'h00A);
      start_op(1'b0, 1'b0, 1'b0, 1'b0, '0);
      wait_done();
      check_eq("mul_out", 32'(Out), 32'h0078);

      // signed overflow: 0x7FE0 chained into dest, + 0x20
      setup(4'd10, 10'h3FF, 10'h020);
      start_op(1'b0, 1'b0, 1'b0, 1'b0, '0);
      wait_done();
      check_eq("mul_big", 32'(Out), 32'h7FE0);
      load(1'b1, 1'b1, 1'b0, 1'b1, 10'h020);
      start_op(1'b0, 1'b0, 1'b0, 1'b0, '0);
      wait_done();
      check_eq("ovf_out", 32'(Out), 32'h8000);
      check_eq("ovf_f", 32'(Flags[2]), 32'd1);
      check_eq("ovf_n", 32'(Flags[4]), 32'd1);
      check_eq("ovf_c", 32'(Flags[0]), 32'd0);

      // SUB borrow, then CMP on the chained result, then ADD wrap
      setup(4'd1, 10'h000, 10'h001);
      start_op(1'b0, 1'b0, 1'b0, 1'b0, '0);
      wait_done();
      check_eq("sub_out", 32'(Out), 32'hFFFF);
      check_eq("sub_c", 32'(Flags[0]), 32'd1);
      load(1'b1, 1'b0, 1'b0, 1'b1, 10'h006);
      start_op(1'b0, 1'b0, 1'b0, 1'b0, '0);
      wait_done();
      check_eq("cmp_out_kept", 32'(Out), 32'hFFFF);
      check_eq("cmp_l", 32'(Flags[1]), 32'd0);
      check_eq("cmp_n", 32'(Flags[4]), 32'd1);
      check_eq("cmp_z", 32'(Flags[3]), 32'd0);
      load(1'b1, 1'b0, 1'b0, 1'b1, 10'h000);
      start_op(1'b0, 1'b0, 1'b0, 1'b0, '0);
      wait_done();
      check_eq("chain_out", 32'(Out), 32'h0000);
      check_eq("chain_z", 32'(Flags[3]), 32'd1);

      // invalid opcode, zero shift amount, all strobes from one bus value, ld_acc over ld_dest
      load(1'b1, 1'b0, 1'b0, 1'b0, 10'h00C);
      start_op(1'b0, 1'b0, 1'b0, 1'b0, '0);
      wait_done();
      setup(4'd8, 10'h1AB, 10'h010);
      start_op(1'b0, 1'b0, 1'b0, 1'b0, '0);
      wait_done();
      check_eq("rsh0_out", 32'(Out), 32'h01AB);
      load(1'b1, 1'b1, 1'b1, 1'b0, 10'h005);
      start_op(1'b0, 1'b0, 1'b0, 1'b0, '0);
      wait_done();
      check_eq("not_out", 32'(Out), 32'hFFFA);
      load(1'b1, 1'b0, 1'b1, 1'b1, 10'h159);
      start_op(1'b0, 1'b0, 1'b0, 1'b0, '0);
      wait_done();

      // randomized: loads, chaining, loads coinciding with start
      for (int i = 0; i < 150; i++) begin
         rop = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(7, 10)) : 4'($urandom_range(0, 15));
         load(1'b1, 1'b0, 1'b0, 1'b0, {6'($urandom), rop});
         if ($urandom_range(0, 3) == 0) load(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, IN_W'($urandom));
         else load(1'b0, 1'b0, 1'b1, 1'b0, IN_W'($urandom));
         load(1'b0, 1'b1, 1'b0, 1'b0, IN_W'($urandom));
         start_op(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), IN_W'($urandom));
         wait_done();
      end

      // reset during MUL iteration
      setup(4'd10, 10'h3FF, 10'h3FF);
      start_op(1'b0, 1'b0, 1'b0, 1'b0, '0);
      repeat (4) tick();
      check_eq("mul_busy_before_rst", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      check_eq("midrst_busy", 32'(busy), 32'd0);
      check_eq("midrst_done", 32'(done), 32'd0);
      check_eq("midrst_out", 32'(Out), 32'd0);
      check_eq("midrst_flags", 32'(Flags), 32'd0);
      check_eq("midrst_state", 32'(dbg_state), 32'd0);
      reset = 1'b0;
      exp_q.delete();
      lat_q.delete();
      model_reset();
      saw_done = 1'b0;
      repeat (W + 4) begin
         tick();
         if (done !== 1'b0) saw_done = 1'b1;
      end
      check_eq("no_done_after_rst", 32'(saw_done), 32'd0);
      start_op(1'b0, 1'b0, 1'b0, 1'b0, '0);
      wait_done();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
